// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB NRZI receive path.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: none.
package usb_rx_pkg;

  // Differential line states as seen on {dp, dm}.
  typedef enum logic [1:0] {
    LS_J,
    LS_K,
    LS_SE0,
    LS_SE1
  } line_state_t;

  // Receiver framing states.
  typedef enum logic [2:0] {
    IDLE,
    DATA,
    EOP1,
    EOP2,
    ERR
  } rx_state_t;

  // SYNC is a run of at least this many decoded zeros closed by a one.
  localparam logic [2:0] SYNC_MIN_ZEROS = 3'd6;

  // After this many consecutive ones the transmitter inserts a zero.
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Map the raw line pair onto a line state.
  function automatic line_state_t classify(input logic dp, input logic dm);
    line_state_t ls;
    case ({dp, dm})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b00:   ls = LS_SE0;
      default: ls = LS_SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/nrzi_rx_if.sv
// Line-side inputs and decoded-stream outputs of the NRZI receiver.
// Latency: n/a (signal bundle only).
// Backpressure: none; the decoded stream is push-only, one bit per strobe.
interface nrzi_rx_if;
  // line side
  logic bit_en;
  logic rx_en;
  logic dp;
  logic dm;
  // decoded stream and status
  logic bit_out;
  logic bit_valid;
  logic sync_det;
  logic eop_det;
  logic stuff_err;
  logic line_err;
  logic busy;

  // Driver of the line, consumer of the decoded stream.
  modport master (
    output bit_en, rx_en, dp, dm,
    input  bit_out, bit_valid, sync_det, eop_det, stuff_err, line_err, busy
  );

  // The receiver itself.
  modport slave (
    input  bit_en, rx_en, dp, dm,
    output bit_out, bit_valid, sync_det, eop_det, stuff_err, line_err, busy
  );
endinterface

// File: rtl/nrzi_rx_unstuff.sv
// Bit-unstuffer: tracks consecutive ones and classifies each decoded data bit.
// Latency: outputs are combinational on the strobe; ones_cnt updates at the next edge.
// Backpressure: none; every strobed bit is classified in the cycle it arrives.
module nrzi_unstuff
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,        // restart the run count (new packet or receiver off)
  input  logic bit_stb,    // a decoded data bit is presented this cycle
  input  logic bit_in,     // the decoded data bit
  output logic data_vld,   // bit is payload
  output logic drop,       // bit is a stuffed zero, discard it
  output logic stuff_err   // a one arrived where a stuffed zero was due
);

  logic [2:0] ones_cnt_q;
  logic [2:0] ones_cnt_d;

  // Classify the strobed bit against the current run of ones.
  always_comb begin
    ones_cnt_d = ones_cnt_q;
    data_vld   = 1'b0;
    drop       = 1'b0;
    stuff_err  = 1'b0;
    if (clr) begin
      ones_cnt_d = '0;
    end else if (bit_stb) begin
      if (ones_cnt_q == STUFF_LIMIT) begin
        // This position must carry the inserted zero.
        if (bit_in) begin
          stuff_err = 1'b1;
        end else begin
          drop       = 1'b1;
          ones_cnt_d = '0;
        end
      end else begin
        data_vld   = 1'b1;
        ones_cnt_d = bit_in ? (ones_cnt_q + 3'd1) : 3'd0;
      end
    end
  end

  // Run-length register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt_q <= '0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end

endmodule

// File: rtl/nrzi_rx.sv
// USB NRZI receiver: line classify, SYNC hunt, NRZI decode, unstuff, EOP detect.
// Latency: one cycle from a bit_en sample to its registered pulse.
// Backpressure: none; define NRZI_RX_SE1_ERR_EN to flag SE1 inside a packet as line_err.
module nrzi_rx
  import usb_rx_pkg::*;
(
  input logic     clk,
  input logic     rst,
  nrzi_rx_if.slave bus
);

  // Framing state and counters.
  rx_state_t   state_q, state_d;
  logic [2:0]  zero_cnt_q, zero_cnt_d;
  line_state_t prev_line_q, prev_line_d;   // only ever LS_J or LS_K
  logic        se0_seen_q, se0_seen_d;     // ERR recovery: last sample was SE0

  // Registered outputs.
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic sync_det_q, sync_det_d;
  logic eop_det_q, eop_det_d;
  logic stuff_err_q, stuff_err_d;
  logic line_err_q, line_err_d;
  logic busy_q, busy_d;

  // Sample decode.
  line_state_t ls_raw;
  line_state_t ls;
  logic        se1_fault;
  logic        dec_bit;
  logic        sync_hit;

  // Unstuffer hookup.
  logic us_clr;
  logic us_stb;
  logic us_vld;
  logic us_drop;
  logic us_err;

  // Classify the line; SE1 reads as J unless it is being flagged as a fault.
  always_comb begin
    ls_raw = classify(bus.dp, bus.dm);
    ls     = (ls_raw == LS_SE1) ? LS_J : ls_raw;
`ifdef NRZI_RX_SE1_ERR_EN
    se1_fault = (ls_raw == LS_SE1) && (state_q inside {DATA, EOP1, EOP2});
`else
    se1_fault = 1'b0;
`endif
    // SE0 never equals prev_line, so it always decodes as 0 and never matches SYNC.
    dec_bit = (ls == prev_line_q);
  end

  // SYNC closes on a decoded one after enough zeros; it also restarts the unstuffer.
  assign sync_hit = bus.rx_en && bus.bit_en && (state_q == IDLE) &&
                    dec_bit && (zero_cnt_q >= SYNC_MIN_ZEROS);
  assign us_clr   = !bus.rx_en || sync_hit;
  assign us_stb   = bus.rx_en && bus.bit_en && (state_q == DATA) &&
                    (ls != LS_SE0) && !se1_fault;

  nrzi_unstuff u_unstuff (
    .clk       (clk),
    .rst       (rst),
    .clr       (us_clr),
    .bit_stb   (us_stb),
    .bit_in    (dec_bit),
    .data_vld  (us_vld),
    .drop      (us_drop),
    .stuff_err (us_err)
  );

  // Next-state and pulse computation for one bit time.
  always_comb begin
    state_d     = state_q;
    zero_cnt_d  = zero_cnt_q;
    prev_line_d = prev_line_q;
    se0_seen_d  = se0_seen_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    sync_det_d  = 1'b0;
    eop_det_d   = 1'b0;
    stuff_err_d = 1'b0;
    line_err_d  = 1'b0;

    if (!bus.rx_en) begin
      // Receiver off: abandon any packet silently and re-arm from scratch.
      state_d     = IDLE;
      zero_cnt_d  = '0;
      prev_line_d = LS_J;
      se0_seen_d  = 1'b0;
    end else if (bus.bit_en) begin
      if (!se1_fault && (ls == LS_J || ls == LS_K)) begin
        prev_line_d = ls;
      end

      if (se1_fault) begin
        line_err_d = 1'b1;
        state_d    = ERR;
        se0_seen_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ls == LS_SE0) begin
              zero_cnt_d = '0;
            end else if (!dec_bit) begin
              zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : (zero_cnt_q + 3'd1);
            end else if (sync_hit) begin
              // Zero count is cleared here too so a later IDLE cannot re-sync on stale zeros.
              sync_det_d = 1'b1;
              zero_cnt_d = '0;
              state_d    = DATA;
            end else begin
              zero_cnt_d = '0;
            end
          end

          DATA: begin
            if (ls == LS_SE0) begin
              state_d = EOP1;
            end else begin
              case (1'b1)
                us_err: begin
                  stuff_err_d = 1'b1;
                  state_d     = ERR;
                  se0_seen_d  = 1'b0;
                end
                us_vld: begin
                  bit_valid_d = 1'b1;
                  bit_out_d   = dec_bit;
                end
                us_drop: begin
                  // Stuffed zero: consumed without output.
                end
                default: begin
                end
              endcase
            end
          end

          EOP1: begin
            if (ls == LS_SE0) begin
              state_d = EOP2;
            end else begin
              line_err_d = 1'b1;
              state_d    = ERR;
              se0_seen_d = 1'b0;
            end
          end

          EOP2: begin
            if (ls == LS_J) begin
              eop_det_d = 1'b1;
              state_d   = IDLE;
            end else begin
              line_err_d = 1'b1;
              state_d    = ERR;
              se0_seen_d = 1'b0;
            end
          end

          ERR: begin
            // Leave only on an SE0 immediately followed by J (line back to idle).
            if (ls == LS_SE0) begin
              se0_seen_d = 1'b1;
            end else if (ls == LS_J && se0_seen_q) begin
              state_d    = IDLE;
              se0_seen_d = 1'b0;
            end else begin
              se0_seen_d = 1'b0;
            end
          end

          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end

    busy_d = (state_d != IDLE);
  end

  // All state and outputs registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      zero_cnt_q  <= '0;
      prev_line_q <= LS_J;
      se0_seen_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      sync_det_q  <= 1'b0;
      eop_det_q   <= 1'b0;
      stuff_err_q <= 1'b0;
      line_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_cnt_q  <= zero_cnt_d;
      prev_line_q <= prev_line_d;
      se0_seen_q  <= se0_seen_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      sync_det_q  <= sync_det_d;
      eop_det_q   <= eop_det_d;
      stuff_err_q <= stuff_err_d;
      line_err_q  <= line_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.sync_det  = sync_det_q;
  assign bus.eop_det   = eop_det_q;
  assign bus.stuff_err = stuff_err_q;
  assign bus.line_err  = line_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nrzi_rx.sv
// Bench for nrzi_rx: packets are built from payload bits (stuff, NRZI-encode, frame)
// and the expected event stream is the payload itself plus framing events.
// A negedge monitor records every DUT pulse into an event queue.
module tb_nrzi_rx;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam logic [1:0] LSE1 = 2'b11;

  // event codes: 0/1 are data bits
  localparam int EV_SYNC  = 2;
  localparam int EV_EOP   = 3;
  localparam int EV_STUFF = 4;
  localparam int EV_LERR  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nrzi_rx_if bus ();

  nrzi_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] line_q[$];
  int         exp_q[$];
  int         obs_q[$];
  logic [1:0] lvl = LJ;      // line level the encoder last drove (J or K)
  int         gap_max = 2;
  int         multi_cnt = 0;
  int         spur_cnt = 0;
  logic       prev_en = 1'b0;
  int         mon_n;

  // Monitor: log pulses, flag overlapping pulses and pulses not caused by a strobe.
  always @(negedge clk) begin
    mon_n = (bus.bit_valid === 1'b1) + (bus.sync_det === 1'b1) + (bus.eop_det === 1'b1) +
            (bus.stuff_err === 1'b1) + (bus.line_err === 1'b1);
    if (mon_n > 1) multi_cnt++;
    if (mon_n > 0 && !prev_en) spur_cnt++;
    if (bus.bit_valid === 1'b1) obs_q.push_back(int'(bus.bit_out));
    if (bus.sync_det === 1'b1)  obs_q.push_back(EV_SYNC);
    if (bus.eop_det === 1'b1)   obs_q.push_back(EV_EOP);
    if (bus.stuff_err === 1'b1) obs_q.push_back(EV_STUFF);
    if (bus.line_err === 1'b1)  obs_q.push_back(EV_LERR);
    prev_en = (bus.bit_en === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit time: random idle cycles with junk on the line, then a strobed sample.
  task automatic send_ls(input logic [1:0] l);
    int gap;
    gap = $urandom_range(0, gap_max);
    repeat (gap) begin
      bus.dp = 1'($urandom);
      bus.dm = 1'($urandom);
      tick();
    end
    bus.dp     = l[1];
    bus.dm     = l[0];
    bus.bit_en = 1'b1;
    tick();
    bus.bit_en = 1'b0;
    bus.dp     = 1'($urandom);
    bus.dm     = 1'($urandom);
  endtask

  task automatic play();
    while (line_q.size() > 0) send_ls(line_q.pop_front());
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic clear_model();
    line_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it.
  task automatic put_bit(input bit b);
    if (!b) lvl = (lvl == LJ) ? LK : LJ;
    line_q.push_back(lvl);
  endtask

  task automatic put_idle(input int n);
    repeat (n) line_q.push_back(LJ);
    if (n > 0) lvl = LJ;
  endtask

  task automatic put_sync();
    repeat (7) put_bit(1'b0);
    put_bit(1'b1);
    exp_q.push_back(EV_SYNC);
  endtask

  // Payload bits LSB first, with a zero inserted after every six consecutive ones.
  task automatic put_payload(input logic [31:0] v, input int n);
    int run;
    run = 0;
    for (int i = 0; i < n; i++) begin
      put_bit(v[i]);
      exp_q.push_back(int'(v[i]));
      run = v[i] ? run + 1 : 0;
      if (run == 6) begin
        put_bit(1'b0);
        run = 0;
      end
    end
  endtask

  task automatic put_eop();
    line_q.push_back(LSE0);
    line_q.push_back(LSE0);
    line_q.push_back(LJ);
    lvl = LJ;
    exp_q.push_back(EV_EOP);
  endtask

  // Payload biased towards ones so stuffing happens often.
  task automatic put_rand_packet();
    logic [31:0] v;
    int n;
    n = $urandom_range(1, 24);
    for (int i = 0; i < 32; i++) v[i] = ($urandom_range(0, 3) != 0);
    put_sync();
    put_payload(v, n);
    put_eop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_en = 1'b1;
    bus.bit_en = 1'b1;
    bus.dp = 1'b0;
    bus.dm = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (bus.bit_out !== 1'b0)   $display("FAIL reset_bit_out: got %b, expected 0", bus.bit_out);   else n_pass++;
    n_checks++; if (bus.bit_valid !== 1'b0) $display("FAIL reset_bit_valid: got %b, expected 0", bus.bit_valid); else n_pass++;
    n_checks++; if (bus.sync_det !== 1'b0)  $display("FAIL reset_sync_det: got %b, expected 0", bus.sync_det);  else n_pass++;
    n_checks++; if (bus.eop_det !== 1'b0)   $display("FAIL reset_eop_det: got %b, expected 0", bus.eop_det);   else n_pass++;
    n_checks++; if (bus.stuff_err !== 1'b0) $display("FAIL reset_stuff_err: got %b, expected 0", bus.stuff_err); else n_pass++;
    n_checks++; if (bus.line_err !== 1'b0)  $display("FAIL reset_line_err: got %b, expected 0", bus.line_err);  else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)      $display("FAIL reset_busy: got %b, expected 0", bus.busy);      else n_pass++;
    rst = 1'b0;
    bus.bit_en = 1'b0;
    tick();
    lvl = LJ;
    clear_model();
  endtask

  task automatic test_a5();
    logic [31:0] v;
    clear_model();
    v = 32'h0000_00A5;
    put_idle(3);
    put_sync();
    put_payload(v, 8);
    put_eop();
    play();
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL a5_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL a5_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stuffed_ff();
    clear_model();
    put_idle(2);
    put_sync();
    put_payload(32'h0000_00FF, 8);
    put_eop();
    play();
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL ff_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL ff_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stuff_err();
    clear_model();
    put_idle(2);
    put_sync();
    repeat (7) put_bit(1'b1);          // no stuffed zero after the sixth one
    repeat (6) exp_q.push_back(1);
    exp_q.push_back(EV_STUFF);
    play();
    drain();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL stuff_busy_err: got %b, expected 1", bus.busy); else n_pass++;
    tick();
    send_ls(LSE0);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL stuff_busy_se0: got %b, expected 1", bus.busy); else n_pass++;
    tick();
    send_ls(LJ);
    lvl = LJ;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL stuff_busy_idle: got %b, expected 0", bus.busy); else n_pass++;
    tick();
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL stuff_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL stuff_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
  endtask

  // Single-SE0 EOP is malformed; the line then idles (SE0, J) and a good packet follows.
  task automatic test_single_se0();
    clear_model();
    put_idle(2);
    put_sync();
    put_payload(32'($urandom_range(0, 15)), 4);
    line_q.push_back(LSE0);
    line_q.push_back(LJ);
    lvl = LJ;
    exp_q.push_back(EV_LERR);
    line_q.push_back(LSE0);
    line_q.push_back(LJ);
    put_idle(2);
    put_sync();
    put_payload(32'h0000_00A5, 8);
    put_eop();
    play();
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL se0_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL se0_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
  endtask

  // Abort mid-packet, first by rst then by rx_en, each time with a live sample present.
  task automatic test_abort();
    clear_model();
    for (int k = 0; k < 2; k++) begin
      put_idle(2);
      put_sync();
      put_payload(32'h0000_0005, 3);
      play();
      bus.dp = 1'b0;
      bus.dm = 1'b1;
      bus.bit_en = 1'b1;
      if (k == 0) rst = 1'b1;
      else bus.rx_en = 1'b0;
      tick();
      rst = 1'b0;
      bus.rx_en = 1'b1;
      bus.bit_en = 1'b0;
      lvl = LJ;
      @(negedge clk);
      n_checks++;
      if ({bus.bit_valid, bus.sync_det, bus.eop_det, bus.stuff_err, bus.line_err, bus.bit_out} !== 6'b0)
        $display("FAIL abort%0d_pulses: got %b, expected 000000", k,
                 {bus.bit_valid, bus.sync_det, bus.eop_det, bus.stuff_err, bus.line_err, bus.bit_out});
      else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort%0d_busy: got %b, expected 0", k, bus.busy); else n_pass++;
      tick();
    end
    put_idle(1);
    put_rand_packet();
    play();
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL abort_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL abort_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_se1();
    clear_model();
    put_idle(2);
    put_sync();
`ifdef NRZI_RX_SE1_ERR_EN
    put_payload(32'h0000_0002, 2);
    line_q.push_back(LSE1);
    exp_q.push_back(EV_LERR);
    line_q.push_back(LSE0);
    line_q.push_back(LJ);
    lvl = LJ;
`else
    // SE1 reads as J: a 1 if the line was at J, else a 0 (here the sync leaves it at K,
    // so the run of ones entering the payload is zero).
    line_q.push_back(LSE1);
    exp_q.push_back((lvl == LJ) ? 1 : 0);
    lvl = LJ;
    put_payload(32'($urandom_range(0, 255)), 8);
    put_eop();
`endif
    put_idle(1);
    put_rand_packet();
    play();
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL se1_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL se1_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
  endtask

  // Packets with no idle between EOP J and the next SYNC, strobed every cycle.
  task automatic test_back_to_back();
    clear_model();
    gap_max = 0;
    repeat (4) put_rand_packet();
    play();
    drain();
    gap_max = 2;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL b2b_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    clear_model();
    repeat (25) begin
      put_idle($urandom_range(0, 3));
      put_rand_packet();
    end
    play();
    drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL rand_ev%0d: got %0d, expected %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (multi_cnt !== 0) $display("FAIL one_hot_pulses: got %0d overlapping cycles, expected 0", multi_cnt); else n_pass++;
    n_checks++; if (spur_cnt !== 0)  $display("FAIL unstrobed_pulses: got %0d cycles, expected 0", spur_cnt);  else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_en = 1'b1;
    bus.bit_en = 1'b0;
    bus.dp = 1'b1;
    bus.dm = 1'b0;
    test_reset();
    test_a5();
    test_stuffed_ff();
    test_stuff_err();
    test_single_se0();
    test_abort();
    test_se1();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nrzi_rx.md
# nrzi_rx

Receive-side counterpart of the USB NRZI transmit path. It samples the differential line (dp/dm) once per bit strobe, classifies the line state, hunts for SYNC, NRZI-decodes, strips stuffed bits, and detects EOP. Decoded data bits go to the downstream bit-to-byte deserializer/packet decoder as a serial stream, together with packet-boundary and error pulses.

## Interface
- No parameters.
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- bit_en  input  1  one-cycle strobe marking one USB bit time; dp/dm are sampled only when it is high
- rx_en  input  1  receiver enable; when low the block is forced to IDLE
- dp  input  1  D+ line, already synchronized
- dm  input  1  D- line, already synchronized
- bit_out  output  1  decoded, unstuffed data bit; valid only with bit_valid
- bit_valid  output  1  one-cycle pulse, bit_out holds a payload bit
- sync_det  output  1  one-cycle pulse, SYNC recognized
- eop_det  output  1  one-cycle pulse, valid EOP (SE0, SE0, J) completed
- stuff_err  output  1  one-cycle pulse, seventh consecutive 1 received
- line_err  output  1  one-cycle pulse, malformed EOP or SE1 (see Configuration)
- busy  output  1  high in every state except IDLE

## Operation
- Line state: J = dp1/dm0, K = dp0/dm1, SE0 = 00, SE1 = 11.
- NRZI decode: for J or K, decoded bit = 1 if line == prev_line, else 0. prev_line updates on every bit_en with a J or K sample and resets to J.
- States:
  - IDLE: on SE0, clear zero_cnt. On J/K, zero_cnt counts consecutive decoded 0s, saturating at 7. A decoded 1 with zero_cnt >= 6 pulses sync_det, clears ones_cnt, and goes to DATA. Any other decoded 1 clears zero_cnt.
  - DATA, on SE0: go to EOP1, no output.
  - DATA, on J/K, ones_cnt == 6: the bit is a stuffed bit. A decoded 0 is dropped and clears ones_cnt. A decoded 1 pulses stuff_err and goes to ERR.
  - DATA, on J/K, ones_cnt < 6: pulse bit_valid with bit_out = decoded bit. ones_cnt = bit ? ones_cnt+1 : 0.
  - EOP1: SE0 goes to EOP2. Anything else pulses line_err and goes to ERR.
  - EOP2: J pulses eop_det and goes to IDLE. Anything else pulses line_err and goes to ERR.
  - ERR: wait for a J sample that follows an SE0 sample, then go to IDLE with no pulse.
- Counters: ones_cnt is 3 bits, zero_cnt is 3 bits.
- Events on a bit_en cycle with SE1 in DATA: see Configuration.

## Timing
- All outputs are registered. Reset value of every output is 0, state is IDLE, prev_line is J, and both counters are 0.
- Latency: the response to the sample taken at bit_en in cycle n appears in cycle n+1, for exactly one cycle.
- With bit_en low, state, counters and prev_line hold, and all pulses are 0.
- At most one of bit_valid / sync_det / eop_det / stuff_err / line_err is high in any cycle.
- rst has priority over everything. rx_en low takes the next state to IDLE and resets the counters and prev_line, with no pulses, including mid-packet.
- Back-to-back packets: IDLE re-arms on the cycle after eop_det. The SYNC of a new packet may start on the very next bit_en.

## Configuration
- NRZI_RX_SE1_ERR_EN defined: SE1 sampled in DATA, EOP1 or EOP2 pulses line_err and goes to ERR.
- NRZI_RX_SE1_ERR_EN undefined: SE1 is treated as J in every state, and line_err fires only for a malformed EOP.

## Structure
- Package usb_rx_pkg holds:
  - line_state_t enum {LS_J, LS_K, LS_SE0, LS_SE1}
  - rx_state_t enum {IDLE, DATA, EOP1, EOP2, ERR}
  - SYNC_MIN_ZEROS = 6
  - STUFF_LIMIT = 6
- One sub-module, nrzi_unstuff: it owns ones_cnt, takes decoded bit plus strobe, and returns data-valid, drop, and stuff-error. The FSM and NRZI decode stay in nrzi_rx.

## Test plan
- Idle J, then KJKJKJKK, then data 8'hA5 sent LSB first, then SE0 SE0 J. Required: sync_det, then 8 bit_valid pulses with bits 1,0,1,0,0,1,0,1, then eop_det one cycle after the J strobe.
- Payload 8'hFF with a stuffed 0 inserted after the sixth 1. Required: exactly 8 bit_valid pulses, all 1, and no stuff_err.
- Payload of seven consecutive 1s with no stuffed 0. Required: 6 bit_valid pulses, stuff_err on the 7th, and busy high until SE0 followed by J, then IDLE.
- Packet ending SE0, J (single SE0). Required: line_err, no eop_det, and a following valid packet decodes normally.
- rst asserted after 3 data bits, and separately rx_en dropped after 3 data bits. Required: all outputs 0 and busy low on the next cycle, with no eop_det.
- SE1 in DATA. Required: with NRZI_RX_SE1_ERR_EN, line_err. Without it, bit_valid with the bit decoded as J.
